// File: rtl/button_debounce_edge_detector.sv
// button_debounce_edge_detector: per-key 2-FF sync, debounce, press/release pulses
// and optional auto-repeat pulse train while a key is held.
module button_debounce_edge_detector #(
    parameter int NUM_KEYS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESSED, REPEATING} state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic sync1, sync2, p, accept, ks, pp, rp, qp, rep_fire;
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold_cnt, hold_nxt;
        logic [RW-1:0] rep_cnt, rep_nxt;
        state_t state, state_nxt;

        assign p      = sync2 ^ ACTIVE_LOW;
        assign accept = (p != ks) && (db_cnt == D_LAST);

        assign key_state[k]     = ks;
        assign press_pulse[k]   = pp;
        assign release_pulse[k] = rp;
        assign repeat_pulse[k]  = qp;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1    <= ACTIVE_LOW;
                sync2    <= ACTIVE_LOW;
                db_cnt   <= '0;
                ks       <= 1'b0;
                pp       <= 1'b0;
                rp       <= 1'b0;
                qp       <= 1'b0;
                state    <= RELEASED;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                sync1    <= keys_in[k];
                sync2    <= sync1;
                db_cnt   <= (p == ks || accept) ? '0 : db_cnt + 1'b1;
                ks       <= accept ? p : ks;
                pp       <= accept & p;
                rp       <= accept & ~p;
                qp       <= rep_fire;
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                rep_cnt  <= rep_nxt;
            end
        end

        // An accepted release outranks any repeat due on the same edge.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            rep_nxt   = rep_cnt;
            rep_fire  = 1'b0;
            if (accept && !p) begin
                state_nxt = RELEASED;
                hold_nxt  = '0;
                rep_nxt   = '0;
            end else begin
                case (state)
                    RELEASED: begin
                        if (accept) begin
                            state_nxt = PRESSED;
                            hold_nxt  = '0;
                        end
                    end
                    PRESSED: begin
                        if (!repeat_en[k]) begin
                            hold_nxt = '0;
                        end else if (hold_cnt == H_LAST) begin
                            rep_fire  = 1'b1;
                            state_nxt = REPEATING;
                            hold_nxt  = '0;
                            rep_nxt   = '0;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end
                    REPEATING: begin
                        if (!repeat_en[k]) begin
                            state_nxt = PRESSED;
                            hold_nxt  = '0;
                            rep_nxt   = '0;
                        end else if (rep_cnt == R_LAST) begin
                            rep_fire = 1'b1;
                            rep_nxt  = '0;
                        end else begin
                            rep_nxt = rep_cnt + 1'b1;
                        end
                    end
                    default: state_nxt = RELEASED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_button_debounce_edge_detector.sv
// tb_button_debounce_edge_detector: directed checks of debounce latency, bounce
// rejection, simultaneous keys, auto-repeat timing and reset mid-operation.
module tb_button_debounce_edge_detector;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys_in, repeat_en;
    logic [3:0] key_state, press_pulse, release_pulse, repeat_pulse;

    int checks = 0, errors = 0;
    int cyc = 0, ref_c = 0;
    int press_n[4], rel_n[4], rep_n[4], press_at[4], rel_at[4], rep_first[4], rep_last[4];
    int press_cyc, rel_cyc, bad;
    logic [3:0] press_or, rel_or, rep_or, ks_or, rst_or;

    button_debounce_edge_detector #(
        .NUM_KEYS(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_in(keys_in), .repeat_en(repeat_en),
        .key_state(key_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int j = 0; j < 4; j++) begin
            press_n[j] = 0; rel_n[j] = 0; rep_n[j] = 0;
            press_at[j] = -1; rel_at[j] = -1; rep_first[j] = -1; rep_last[j] = -1;
        end
        press_cyc = 0; rel_cyc = 0; bad = 0;
        press_or = '0; rel_or = '0; rep_or = '0; ks_or = '0; rst_or = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) rst_or |= key_state | press_pulse | release_pulse | repeat_pulse;
            if (press_pulse != 0) press_cyc++;
            if (release_pulse != 0) rel_cyc++;
            press_or |= press_pulse;
            rel_or   |= release_pulse;
            rep_or   |= repeat_pulse;
            ks_or    |= key_state;
            if (((press_pulse | release_pulse) & repeat_pulse) != 0) bad++;
            for (int j = 0; j < 4; j++) begin
                if (press_pulse[j]) begin press_n[j]++; press_at[j] = cyc; end
                if (release_pulse[j]) begin rel_n[j]++; rel_at[j] = cyc; end
                if (repeat_pulse[j]) begin
                    if (rep_n[j] == 0) rep_first[j] = cyc;
                    rep_n[j]++;
                    rep_last[j] = cyc;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; keys_in = 4'hF; repeat_en = 4'h0;
        clr();
        run(2);
        check("rst_key_state", key_state, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_repeat", repeat_pulse, 0);
        rst_n = 1'b1;
        run(8);

        // basic press/release on key 0
        clr(); ref_c = cyc; keys_in[0] = 1'b0;
        run(20);
        check("basic_state", key_state, 4'b0001);
        check("basic_press_at", press_at[0], ref_c + 6);
        check("basic_press_cyc", press_cyc, 1);
        check("basic_press_vec", press_or, 4'b0001);
        ref_c = cyc; keys_in[0] = 1'b1;
        run(12);
        check("basic_rel_at", rel_at[0], ref_c + 6);
        check("basic_rel_cyc", rel_cyc, 1);
        check("basic_rel_vec", rel_or, 4'b0001);
        check("basic_state_off", key_state, 0);

        // bounce on key 1: 2-cycle toggles never reach the 4-cycle window
        clr();
        for (int t = 0; t < 15; t++) begin
            keys_in[1] = ~keys_in[1];
            run(2);
        end
        keys_in[1] = 1'b1;
        run(10);
        check("bounce_press", press_or, 0);
        check("bounce_rel", rel_or, 0);
        check("bounce_state", ks_or, 0);

        // all keys together
        clr(); ref_c = cyc; keys_in = 4'h0;
        run(10);
        check("all_state", key_state, 4'hF);
        keys_in = 4'hF;
        run(12);
        check("all_press_vec", press_or, 4'hF);
        check("all_press_cyc", press_cyc, 1);
        check("all_press_at", press_at[3], ref_c + 6);
        check("all_rel_vec", rel_or, 4'hF);
        check("all_rel_cyc", rel_cyc, 1);
        check("all_no_repeat", rep_or, 0);

        // auto-repeat on key 2, key 3 identical but repeat disabled; release lands on a repeat slot
        clr(); repeat_en = 4'b0100; ref_c = cyc; keys_in = 4'b0011;
        run(28);
        keys_in = 4'hF;
        run(12);
        check("rep_press_vec", press_or, 4'b1100);
        check("rep_press_at", press_at[2], ref_c + 6);
        check("rep_first", rep_first[2], ref_c + 16);
        check("rep_last", rep_last[2], ref_c + 31);
        check("rep_count", rep_n[2], 6);
        check("rep_key3_none", rep_n[3], 0);
        check("rep_rel_at", rel_at[2], ref_c + 34);
        check("rep_exclusive", bad, 0);

        // reset while key 0 is repeating
        clr(); repeat_en = 4'b0001; ref_c = cyc; keys_in = 4'b1110;
        run(20);
        check("mid_repeats", rep_n[0], 2);
        rst_n = 1'b0;
        run(2);
        check("mid_rst_outputs", rst_or, 0);
        check("mid_rst_state", key_state, 0);
        clr(); rst_n = 1'b1; ref_c = cyc;
        run(10);
        check("mid_repress_at", press_at[0], ref_c + 6);
        check("mid_repress_n", press_n[0], 1);
        check("mid_state", key_state, 4'b0001);

        keys_in = 4'hF; repeat_en = 4'h0;
        run(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
